hzd_scoreboard: RTL and testbench



---
 rtl/hzd_pkg.sv | 19 +
 rtl/hzd_pending_file.sv | 67 ++++++
 rtl/hzd_scoreboard.sv | 79 +++++++
 tb/tb_hzd_scoreboard.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hzd_pkg.sv
// Shared types and defaults for the D/E hazard scoreboard.
// Register-select width, zero-register constant and stall-cause encoding.
package hzd_pkg;

    localparam int DEF_REG_SELECT      = 5;
    localparam int DEF_MAX_OUTSTANDING = 4;

    typedef logic [DEF_REG_SELECT-1:0] reg_sel_t;

    localparam reg_sel_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        LOAD_USE   = 2'd1,
        SCOREBOARD = 2'd2,
        CAPACITY   = 2'd3
    } stall_cause_t;

endpackage

// File: rtl/hzd_pending_file.sv
// Per-register pending bits plus in-flight long-write counter; 1-cycle set/clear latency,
// bypassed read view drops a register whose writeback lands this cycle; no backpressure of its own.
module hzd_pending_file
    import hzd_pkg::*;
#(
    parameter  int REG_SELECT      = DEF_REG_SELECT,
    parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int NUM_REGS        = 2**REG_SELECT,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_set_vld,
    input  logic [REG_SELECT-1:0] i_set_sel,
    input  logic                  i_clr_vld,
    input  logic [REG_SELECT-1:0] i_clr_sel,
    output logic [NUM_REGS-1:0]   o_pending,
    output logic [NUM_REGS-1:0]   o_pending_byp,
    output logic                  o_clr_hit,
    output logic [CNT_W-1:0]      o_outstanding
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                set_en;
    logic                clr_en;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_en   = i_set_vld && (i_set_sel != '0);
        clr_en   = i_clr_vld && pending_q[i_clr_sel];
        set_mask[i_set_sel] = set_en;
        clr_mask[i_clr_sel] = i_clr_vld;

        // Clear before set so a same-register issue/writeback leaves the bit set.
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;

        count_d = count_q;
        if (set_en && !clr_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (clr_en && !set_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign o_pending     = pending_q;
    assign o_pending_byp = pending_q & ~clr_mask;
    assign o_clr_hit     = clr_en;
    assign o_outstanding = count_q;

endmodule

// File: rtl/hzd_scoreboard.sv
// D-stage hazard detect (load-use, pending-register, long-op capacity); stall/bubble are 0-cycle combinational,
// scoreboard updates on the next edge; the D instruction is held for as long as o_stall_D is high.
module hzd_scoreboard
    import hzd_pkg::*;
#(
    parameter  int REG_SELECT      = DEF_REG_SELECT,
    parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int NUM_REGS        = 2**REG_SELECT,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_SELECT-1:0] i_reg_a_select,
    input  logic [REG_SELECT-1:0] i_reg_b_select,
    input  logic                  i_use_a,
    input  logic                  i_use_b,
    input  logic [REG_SELECT-1:0] i_reg_c_select_D,
    input  logic                  i_is_write_D,
    input  logic                  i_issue_valid,
    input  logic                  i_issue_long,
    input  logic                  i_is_load_E,
    input  logic [REG_SELECT-1:0] i_reg_c_select_E,
    input  logic                  i_wb_long_valid,
    input  logic [REG_SELECT-1:0] i_wb_long_select,
    output logic                  o_stall_D,
    output logic                  o_bubble_E,
    output logic [NUM_REGS-1:0]   o_pending,
    output logic [CNT_W-1:0]      o_outstanding,
    output logic                  o_busy
);

    logic [NUM_REGS-1:0] pending_byp;
    logic                clr_hit;
    logic                scb_hit;
    logic                lu_hit;
    logic                cap_hit;
    logic                stall;
    logic                issue_fire;
    logic                set_vld;

    hzd_pending_file #(
        .REG_SELECT      (REG_SELECT),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_pending (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_set_vld     (set_vld),
        .i_set_sel     (i_reg_c_select_D),
        .i_clr_vld     (i_wb_long_valid),
        .i_clr_sel     (i_wb_long_select),
        .o_pending     (o_pending),
        .o_pending_byp (pending_byp),
        .o_clr_hit     (clr_hit),
        .o_outstanding (o_outstanding)
    );

    // Register 0 never holds a pending bit, so it can never raise scb_hit.
    always_comb begin
        scb_hit = (i_use_a      && pending_byp[i_reg_a_select])
               || (i_use_b      && pending_byp[i_reg_b_select])
               || (i_is_write_D && pending_byp[i_reg_c_select_D]);

        lu_hit  = i_is_load_E && (i_reg_c_select_E != '0)
               && ((i_use_a && (i_reg_a_select == i_reg_c_select_E))
                || (i_use_b && (i_reg_b_select == i_reg_c_select_E)));

        cap_hit = i_issue_long && (o_outstanding == CNT_W'(MAX_OUTSTANDING)) && !clr_hit;

        // Outputs are forced low while reset is asserted, regardless of E-stage inputs.
        stall      = i_rst_n && i_issue_valid && (scb_hit || lu_hit || cap_hit);
        issue_fire = i_issue_valid && !stall;
        set_vld    = issue_fire && i_issue_long && i_is_write_D;
    end

    assign o_stall_D  = stall;
    assign o_bubble_E = stall;
    assign o_busy     = (o_outstanding != '0);

endmodule

// File: tb/tb_hzd_scoreboard.sv
// Directed bench for hzd_scoreboard: load-use, long dependency, WAW, capacity, same-register set/clear, async reset.
module tb_hzd_scoreboard;
    import hzd_pkg::*;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    reg_sel_t       i_reg_a_select, i_reg_b_select, i_reg_c_select_D, i_reg_c_select_E, i_wb_long_select;
    logic           i_use_a, i_use_b, i_is_write_D, i_issue_valid, i_issue_long, i_is_load_E, i_wb_long_valid;
    logic           o_stall_D, o_bubble_E, o_busy;
    logic [31:0]    o_pending;
    logic [2:0]     o_outstanding;

    int n_pass  = 0;
    int n_total = 0;

    hzd_scoreboard dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_reg_a_select   (i_reg_a_select),
        .i_reg_b_select   (i_reg_b_select),
        .i_use_a          (i_use_a),
        .i_use_b          (i_use_b),
        .i_reg_c_select_D (i_reg_c_select_D),
        .i_is_write_D     (i_is_write_D),
        .i_issue_valid    (i_issue_valid),
        .i_issue_long     (i_issue_long),
        .i_is_load_E      (i_is_load_E),
        .i_reg_c_select_E (i_reg_c_select_E),
        .i_wb_long_valid  (i_wb_long_valid),
        .i_wb_long_select (i_wb_long_select),
        .o_stall_D        (o_stall_D),
        .o_bubble_E       (o_bubble_E),
        .o_pending        (o_pending),
        .o_outstanding    (o_outstanding),
        .o_busy           (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_stall(input string tag, input stall_cause_t cause);
        chk({tag, ".stall"},  {31'd0, o_stall_D},  {31'd0, cause != NONE});
        chk({tag, ".bubble"}, {31'd0, o_bubble_E}, {31'd0, cause != NONE});
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pend, input int cnt);
        chk({tag, ".pending"},     o_pending,                  pend);
        chk({tag, ".outstanding"}, {29'd0, o_outstanding},     cnt[31:0]);
        chk({tag, ".busy"},        {31'd0, o_busy},            {31'd0, cnt != 0});
    endtask

    task automatic set_d(input logic vld, input logic lng, input logic wr, input reg_sel_t rd,
                         input logic ua, input reg_sel_t ra, input logic ub, input reg_sel_t rb);
        i_issue_valid    = vld;
        i_issue_long     = lng;
        i_is_write_D     = wr;
        i_reg_c_select_D = rd;
        i_use_a          = ua;
        i_reg_a_select   = ra;
        i_use_b          = ub;
        i_reg_b_select   = rb;
    endtask

    task automatic set_e(input logic ld, input reg_sel_t rd);
        i_is_load_E      = ld;
        i_reg_c_select_E = rd;
    endtask

    task automatic set_wb(input logic vld, input reg_sel_t sel);
        i_wb_long_valid  = vld;
        i_wb_long_select = sel;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        set_wb(0, REG_ZERO);
        // Reset with a live load-use pattern: outputs still read 0
        set_e(1, 5'd5);
        set_d(1, 0, 0, REG_ZERO, 1, 5'd5, 0, REG_ZERO);
        #2;
        chk_state("reset", 32'h0, 0);
        chk_stall("reset", NONE);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;

        // Load-use on rs1, one cycle only
        chk_stall("lu_rs1", LOAD_USE);
        tick();
        set_e(0, 5'd5);
        #1;
        chk_stall("lu_gone", NONE);
        set_e(1, REG_ZERO);
        set_d(1, 0, 0, REG_ZERO, 1, REG_ZERO, 0, REG_ZERO);
        #1;
        chk_stall("lu_rd0", NONE);
        set_e(1, 5'd5);
        set_d(1, 0, 0, REG_ZERO, 0, 5'd5, 1, 5'd6);
        #1;
        chk_stall("lu_unused_src", NONE);
        set_e(0, REG_ZERO);

        // Long issue rd=7, then dependent read on rs2
        set_d(1, 1, 1, 5'd7, 0, REG_ZERO, 0, REG_ZERO);
        #1;
        chk_stall("long7_issue", NONE);
        tick();
        chk_state("long7_set", 32'h0000_0080, 1);
        set_d(1, 0, 0, REG_ZERO, 0, REG_ZERO, 1, 5'd7);
        #1;
        chk_stall("dep7", SCOREBOARD);
        tick();
        chk_stall("dep7_hold", SCOREBOARD);
        set_wb(1, 5'd7);
        #1;
        chk_stall("dep7_wb", NONE);
        chk("dep7_wb.pending_pre", o_pending, 32'h0000_0080);
        tick();
        set_wb(0, REG_ZERO);
        set_d(0, 0, 0, REG_ZERO, 0, REG_ZERO, 0, REG_ZERO);
        chk_state("dep7_clr", 32'h0, 0);

        // WAW on rd=9
        set_d(1, 1, 1, 5'd9, 0, REG_ZERO, 0, REG_ZERO);
        tick();
        chk_state("long9_set", 32'h0000_0200, 1);
        set_d(1, 0, 1, 5'd9, 0, REG_ZERO, 0, REG_ZERO);
        #1;
        chk_stall("waw9", SCOREBOARD);
        tick();
        chk_stall("waw9_hold", SCOREBOARD);
        set_wb(1, 5'd9);
        #1;
        chk_stall("waw9_wb", NONE);
        tick();
        set_wb(0, REG_ZERO);
        set_d(0, 0, 0, REG_ZERO, 0, REG_ZERO, 0, REG_ZERO);
        chk_state("waw9_clr", 32'h0, 0);

        // Capacity: fill rd=1..4, fifth long op stalls unless a writeback frees a slot
        for (int r = 1; r <= 4; r++) begin
            set_d(1, 1, 1, reg_sel_t'(r), 0, REG_ZERO, 0, REG_ZERO);
            #1;
            chk_stall("cap_fill", NONE);
            tick();
        end
        chk_state("cap_full", 32'h0000_001E, 4);
        set_d(1, 1, 1, 5'd6, 0, REG_ZERO, 0, REG_ZERO);
        #1;
        chk_stall("cap5", CAPACITY);
        set_wb(1, 5'd1);
        #1;
        chk_stall("cap5_wb", NONE);
        tick();
        chk_state("cap5_after", 32'h0000_005C, 4);

        // Writebacks to non-pending registers (1 and 0) change nothing
        set_d(0, 0, 0, REG_ZERO, 0, REG_ZERO, 0, REG_ZERO);
        tick();
        chk_state("wb_stray1", 32'h0000_005C, 4);
        set_wb(1, REG_ZERO);
        tick();
        chk_state("wb_stray0", 32'h0000_005C, 4);

        // Same register: pending[3] with writeback 3 and new long issue to 3
        set_wb(0, REG_ZERO);
        set_d(1, 1, 1, 5'd3, 0, REG_ZERO, 0, REG_ZERO);
        #1;
        chk_stall("same3_nowb", CAPACITY);
        set_wb(1, 5'd3);
        #1;
        chk_stall("same3", NONE);
        tick();
        chk_state("same3_after", 32'h0000_005C, 4);

        // Different registers: free slot via wb 2, then issue 10 with wb 4
        set_d(0, 0, 0, REG_ZERO, 0, REG_ZERO, 0, REG_ZERO);
        set_wb(1, 5'd2);
        tick();
        chk_state("wb2", 32'h0000_0058, 3);
        set_d(1, 1, 1, 5'd10, 0, REG_ZERO, 0, REG_ZERO);
        set_wb(1, 5'd4);
        #1;
        chk_stall("diff10_4", NONE);
        tick();
        chk_state("diff10_4_after", 32'h0000_0448, 3);

        // Long op writing r0 never creates a pending bit
        set_wb(0, REG_ZERO);
        set_d(1, 1, 1, REG_ZERO, 1, REG_ZERO, 0, REG_ZERO);
        #1;
        chk_stall("long_r0", NONE);
        tick();
        chk_state("long_r0_after", 32'h0000_0448, 3);

        // Asynchronous reset between edges with state in flight
        set_d(1, 0, 0, REG_ZERO, 1, 5'd10, 0, REG_ZERO);
        #1;
        chk_stall("pre_rst_dep10", SCOREBOARD);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_state("mid_rst", 32'h0, 0);
        chk_stall("mid_rst", NONE);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk_stall("post_rst_dep10", NONE);
        set_e(1, 5'd10);
        #1;
        chk_stall("post_rst_lu", LOAD_USE);
        tick();
        chk_state("post_rst_state", 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
